// File: rtl/keypad_pkg.sv
// Shared definitions for the front-panel keypad scanner.
// Holds key-code constants, the scanner FSM encoding and the
// row/column helpers used by the scanner datapath.
package keypad_pkg;

   localparam logic [3:0] KEY_CLEAR   = 4'hA;
   localparam logic [3:0] KEY_ENTER   = 4'hB;
   localparam logic [3:0] KEY_RESTART = 4'hC;
   localparam logic [3:0] KEY_NONE    = 4'hF;

   // Column drive after reset (column 0 driven low) and idle row pattern.
   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROW_IDLE  = 4'b1111;

   typedef enum logic [2:0] {
      ST_SCAN     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_LOAD     = 3'd2,
      ST_PULSE    = 3'd3,
      ST_RELEASE  = 3'd4
   } state_t;

   // Key code for the switch at (row_idx, col_idx).
   function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = KEY_CLEAR;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = KEY_ENTER;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = KEY_RESTART;
         4'hC:    code = KEY_NONE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hE;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // True when exactly one line of an active-low group is asserted.
   function automatic logic one_low(input logic [3:0] v);
      return ($countones(~v) == 1);
   endfunction

   // Index of the lowest asserted (low) line; 0 when none is low.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Active-low pattern with only line idx asserted.
   function automatic logic [3:0] row_pattern(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// row_sync: 2-flop synchroniser for the asynchronous keypad row lines.
// Ports: clk_i, reset_i (sync, active-high), row_i (raw rows), rs_o (synchronised rows).
// Latency 2 cycles; no flow control, resets to the idle (all-high) pattern.
module row_sync
   import keypad_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] row_i,
   output logic [3:0] rs_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= ROW_IDLE;
         sync_q <= ROW_IDLE;
      end else begin
         meta_q <= row_i;
         sync_q <= meta_q;
      end
   end

   assign rs_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix, debounces one key and emits key code + stretched press.
// Ports: Clock, reset (sync, active-high), row (raw rows), col (column drive), key (code), press (pulse).
// Press rises (DEBOUNCE-1)*SCAN_DIV+2 cycles after the first sampling tick that sees the key; no backpressure.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 5000,
   parameter int DEBOUNCE  = 4,
   parameter int PRESS_LEN = 64
) (
   input  logic       Clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       press
);

   localparam int                DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]        DB_N     = 4'(DEBOUNCE);
   localparam logic [9:0]        PL_LAST  = 10'(PRESS_LEN - 1);

   logic [3:0]       rs;
   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       col_q, col_d;
   logic [3:0]       key_q, key_d;
   logic             press_q, press_d;
   logic [3:0]       dcnt_q, dcnt_d;
   logic [9:0]       pcnt_q, pcnt_d;
   logic [1:0]       cand_row_q, cand_row_d;
   logic [1:0]       cand_col_q, cand_col_d;

   logic             tick;
   logic             hit;
   logic [3:0]       dcnt_inc;

   row_sync u_row_sync (
      .clk_i   (Clock),
      .reset_i (reset),
      .row_i   (row),
      .rs_o    (rs)
   );

   assign tick     = (div_q == DIV_LAST);
   assign div_d    = tick ? '0 : div_q + 1'b1;
   assign hit      = one_low(rs);
   // Saturating so a long run of stable samples can never wrap back to a small count.
   assign dcnt_inc = (dcnt_q == 4'hF) ? dcnt_q : dcnt_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      key_d      = key_q;
      dcnt_d     = dcnt_q;
      pcnt_d     = pcnt_q;
      cand_row_d = cand_row_q;
      cand_col_d = cand_col_q;

      case (state_q)
         ST_SCAN: begin
            if (tick) begin
               if (hit) begin
                  // Column stays frozen from here on until the FSM is back in SCAN.
                  cand_row_d = low_idx(rs);
                  cand_col_d = low_idx(col_q);
                  dcnt_d     = 4'd1;
                  if (DB_N == 4'd1) begin
                     // Key is published on entry to LOAD so it leads press by a cycle.
                     key_d   = key_map(low_idx(rs), low_idx(col_q));
                     dcnt_d  = 4'd0;
                     state_d = ST_LOAD;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end else begin
                  col_d = {col_q[2:0], col_q[3]};
               end
            end
         end

         ST_DEBOUNCE: begin
            if (tick) begin
               if (rs == row_pattern(cand_row_q)) begin
                  dcnt_d = dcnt_inc;
                  if (dcnt_inc == DB_N) begin
                     key_d   = key_map(cand_row_q, cand_col_q);
                     dcnt_d  = 4'd0;
                     state_d = ST_LOAD;
                  end
               end else begin
                  // Rotation resumes from the frozen column on the next idle tick.
                  dcnt_d  = 4'd0;
                  state_d = ST_SCAN;
               end
            end
         end

         ST_LOAD: begin
            pcnt_d  = 10'd0;
            state_d = ST_PULSE;
         end

         ST_PULSE: begin
            // Rows are deliberately ignored here: contact bounce cannot retrigger.
            if (pcnt_q == PL_LAST) begin
               pcnt_d  = 10'd0;
               dcnt_d  = 4'd0;
               state_d = ST_RELEASE;
            end else begin
               pcnt_d = pcnt_q + 10'd1;
            end
         end

         ST_RELEASE: begin
            // A held key keeps this state forever, which is what prevents auto-repeat.
            if (tick) begin
               if (rs == ROW_IDLE) begin
                  dcnt_d = dcnt_inc;
                  if (dcnt_inc == DB_N) begin
                     dcnt_d  = 4'd0;
                     state_d = ST_SCAN;
                  end
               end else begin
                  dcnt_d = 4'd0;
               end
            end
         end

         default: begin
            dcnt_d  = 4'd0;
            pcnt_d  = 10'd0;
            state_d = ST_SCAN;
         end
      endcase
   end

   // Registered from the next state so press is glitch-free and exactly PRESS_LEN wide.
   assign press_d = (state_d == ST_PULSE);

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q    <= ST_SCAN;
         div_q      <= '0;
         col_q      <= COL_RESET;
         key_q      <= KEY_NONE;
         press_q    <= 1'b0;
         dcnt_q     <= 4'd0;
         pcnt_q     <= 10'd0;
         cand_row_q <= 2'd0;
         cand_col_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         col_q      <= col_d;
         key_q      <= key_d;
         press_q    <= press_d;
         dcnt_q     <= dcnt_d;
         pcnt_q     <= pcnt_d;
         cand_row_q <= cand_row_d;
         cand_col_q <= cand_col_d;
      end
   end

   assign col   = col_q;
   assign key   = key_q;
   assign press = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model driven from col, cycle-level reference model.
// Directed scenarios followed by randomized key presses.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 3;
   localparam int PL = 8;

   localparam int MS_SCAN = 0;
   localparam int MS_DEB  = 1;
   localparam int MS_BUSY = 2;
   localparam int MS_REL  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key;
   logic        press;
   logic [15:0] down;     // bit r*4+c set = switch at (r,c) closed

   always #5 clk = ~clk;

   function automatic logic [3:0] mat_rows(input logic [3:0] c, input logic [15:0] d);
      logic [3:0] r;
      r = 4'b1111;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (d[i*4+j] && !c[j]) r[i] = 1'b0;
      return r;
   endfunction

   assign row = mat_rows(col, down);

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB), .PRESS_LEN(PL)) dut (
      .Clock (clk),
      .reset (reset),
      .row   (row),
      .col   (col),
      .key   (key),
      .press (press)
   );

   // Key legend in row-major order.
   logic [3:0] kmap [16];

   // Reference model state (values for the current cycle).
   int         m_n, m_ci, m_mode, m_cnt, m_crow, m_ccol, m_pstart, m_pend;
   logic [3:0] m_key, m_s1, m_s2;

   int         n_vec, n_bad;
   int         dut_rises, mdl_rises, pw;
   logic       prev_press, prev_mpress;
   logic [3:0] key_prev, exp_key;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] mcol();
      logic [3:0] c;
      c = 4'b0001 << m_ci;
      return ~c;
   endfunction

   function automatic logic mpress();
      return (m_mode == MS_BUSY) && (m_n >= m_pstart);
   endfunction

   function automatic int lowpos(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (!v[i]) return i;
      return 0;
   endfunction

   // Advance the model across the coming clock edge using this cycle's inputs.
   task automatic model_step();
      logic [3:0] rin, rs;
      bit         tk;
      rin = mat_rows(mcol(), down);
      if (reset) begin
         m_n = 0; m_ci = 0; m_mode = MS_SCAN; m_cnt = 0;
         m_key = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF;
         m_pstart = 0; m_pend = 0;
         return;
      end
      rs = m_s2;                       // rows as seen two cycles ago
      tk = ((m_n % SD) == SD - 1);
      case (m_mode)
         MS_SCAN: if (tk) begin
            if ($countones(~rs) == 1) begin
               m_crow = lowpos(rs); m_ccol = m_ci; m_cnt = 1;
               m_mode = MS_DEB;
               if (m_cnt >= DB) begin
                  m_key = kmap[m_crow*4 + m_ccol];
                  m_pstart = m_n + 2; m_pend = m_n + 2 + PL; m_mode = MS_BUSY;
               end
            end else begin
               m_ci = (m_ci + 1) % 4;
            end
         end
         MS_DEB: if (tk) begin
            if ($countones(~rs) == 1 && lowpos(rs) == m_crow) begin
               m_cnt++;
               if (m_cnt == DB) begin
                  m_key = kmap[m_crow*4 + m_ccol];
                  m_pstart = m_n + 2; m_pend = m_n + 2 + PL; m_mode = MS_BUSY;
               end
            end else begin
               m_cnt = 0; m_mode = MS_SCAN;
            end
         end
         MS_BUSY: if (m_n == m_pend - 1) begin
            m_mode = MS_REL; m_cnt = 0;
         end
         default: if (tk) begin
            if (rs == 4'hF) m_cnt++; else m_cnt = 0;
            if (m_cnt == DB) begin m_mode = MS_SCAN; m_cnt = 0; end
         end
      endcase
      m_s2 = m_s1;
      m_s1 = rin;
      m_n++;
   endtask

   // One clock: model edge, then compare at the falling edge.
   task automatic cyc();
      model_step();
      @(negedge clk);
      chk("outs{col,key,press}", {23'd0, col, key, press}, {23'd0, mcol(), m_key, mpress()});
      if (press && !prev_press) begin
         dut_rises++;
         chk("key_before_rise", {28'd0, key_prev}, {28'd0, exp_key});
      end
      if (mpress() && !prev_mpress) mdl_rises++;
      if (press) pw++;
      if (prev_press && !press) begin
         if (!reset) chk("pulse_len", pw, PL);
         pw = 0;
      end
      prev_press  = press;
      prev_mpress = mpress();
      key_prev    = key;
   endtask

   task automatic hold(input int r, input int c, input int n);
      down[r*4+c] = 1'b1;
      repeat (n) cyc();
      down[r*4+c] = 1'b0;
   endtask

   int base;
   int r, c, nb, nh;
   bit seen;

   initial begin
      kmap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hF, 4'h0, 4'hE, 4'hD};
      n_vec = 0; n_bad = 0; dut_rises = 0; mdl_rises = 0; pw = 0;
      prev_press = 1'b0; prev_mpress = 1'b0; key_prev = 4'hF; exp_key = 4'hF;
      reset = 1'b1;
      down  = 16'd0;
      model_step();
      @(negedge clk);

      // 1. reset and idle scan
      repeat (2) cyc();
      chk("rst_col", {28'd0, col}, 32'hE);
      chk("rst_key", {28'd0, key}, 32'hF);
      chk("rst_press", {31'd0, press}, 32'd0);
      reset = 1'b0;
      repeat (40) cyc();
      chk("idle_pulses", dut_rises, 0);

      // 2. clean '5'
      base = dut_rises; exp_key = 4'h5;
      hold(1, 1, 200);
      repeat (40) cyc();
      chk("k5_pulses", dut_rises - base, 1);
      chk("k5_key", {28'd0, key}, 32'h5);

      // 3. bouncy 'B'
      base = dut_rises; exp_key = 4'hB;
      for (int i = 0; i < 10; i++) begin
         down[1*4+3] = ~down[1*4+3];
         cyc();
      end
      chk("kB_no_pulse_in_bounce", dut_rises - base, 0);
      hold(1, 3, 200);
      repeat (40) cyc();
      chk("kB_pulses", dut_rises - base, 1);
      chk("kB_key", {28'd0, key}, 32'hB);

      // 4. one-tick glitch on r2 while c0 is driven
      base = dut_rises;
      for (int i = 0; i < 64 && !(m_n % SD == 0 && m_ci == 0); i++) cyc();
      hold(2, 0, SD);
      repeat (40) cyc();
      chk("glitch_pulses", dut_rises - base, 0);
      chk("glitch_key", {28'd0, key}, 32'hB);

      // 5. ghosting, then '0'
      base = dut_rises;
      down[0*4+1] = 1'b1; down[2*4+1] = 1'b1;
      repeat (100) cyc();
      down = 16'd0;
      repeat (40) cyc();
      chk("ghost_pulses", dut_rises - base, 0);
      exp_key = 4'h0;
      hold(3, 1, 200);
      repeat (40) cyc();
      chk("k0_pulses", dut_rises - base, 1);
      chk("k0_key", {28'd0, key}, 32'h0);

      // 6. reset in the middle of a pulse, then 'C'
      exp_key = 4'h7;
      down[2*4+0] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         cyc();
         if (press) seen = 1'b1;
      end
      chk("pulse_seen_before_timeout", {31'd0, seen}, 32'd1);
      repeat (2) cyc();                  // press now in its 3rd cycle
      reset = 1'b1;
      cyc();
      chk("midrst_press", {31'd0, press}, 32'd0);
      chk("midrst_key", {28'd0, key}, 32'hF);
      reset = 1'b0;
      down  = 16'd0;
      repeat (20) cyc();
      base = dut_rises; exp_key = 4'hC;
      hold(2, 3, 200);
      repeat (40) cyc();
      chk("kC_pulses", dut_rises - base, 1);
      chk("kC_key", {28'd0, key}, 32'hC);

      // Randomized presses with optional bounce and random hold lengths.
      for (int it = 0; it < 25; it++) begin
         r  = $urandom_range(0, 3);
         c  = $urandom_range(0, 3);
         nb = $urandom_range(0, 6);
         nh = $urandom_range(0, 120);
         exp_key = kmap[r*4+c];
         for (int i = 0; i < nb; i++) begin
            down[r*4+c] = ~down[r*4+c];
            cyc();
         end
         hold(r, c, nh);
         repeat ($urandom_range(30, 80)) cyc();
      end
      chk("total_pulses", dut_rises, mdl_rises);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
